dp_dmi_ctrl: RTL

Sequences Debug Module Interface (DMI) transactions between the JTAG side of the debug access port and the debug module bus. It takes the value scanned into the DMI data register (address, data, op) on each update, issues one request/response transaction toward the debug module, and holds the result for the next DMI capture. It also maintains the sticky DMI status (`dmistat`) reported through DTMCS, and supports the `dmireset` and `dmihardreset` controls. All inputs are synchronous to `iclk`; the TAP-side pulses arrive already synchronised.

---
 rtl/dp_constants.sv | 23 ++
 rtl/dp_dmi_timeout.sv | 39 +++
 rtl/dp_dmi_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dp_constants.sv
// dp_constants: shared DMI op, status and FSM state types.
// No ports; imported by dp_dmi_ctrl and its sub-modules.
package dp_constants;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_OK     = 2'd0,
    ST_FAILED = 2'd2,
    ST_BUSY   = 2'd3
  } dmi_stat_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } dmi_state_e;

endpackage

// File: rtl/dp_dmi_timeout.sv
// dp_dmi_timeout: saturating WAIT-cycle counter for one DMI transaction.
// Ports: clk_i, rst_i (sync high), clr_i, en_i, expired_o.
module dp_dmi_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the enabled cycle whose increment brings the count to TIMEOUT.
  assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/dp_dmi_ctrl.sv
// dp_dmi_ctrl: sequences DMI DR updates into DM request/response
// transactions, keeps capture data and sticky dmistat.
// Ports: iclk/ireset, dmi_* from TAP, req_*/resp_* to the DM,
// cap_data/cap_op for capture, dmistat, busy.
module dp_dmi_ctrl
  import dp_constants::*;
#(
  parameter int unsigned ABITS   = 7,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             dmi_upd,
  input  logic             dmi_cap,
  input  logic [ABITS-1:0] dmi_addr,
  input  logic [31:0]      dmi_wdata,
  input  logic [1:0]       dmi_op,
  input  logic             dmireset,
  input  logic             dmihardreset,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [ABITS-1:0] req_addr,
  output logic [31:0]      req_data,
  output logic [1:0]       req_op,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [31:0]      resp_data,
  input  logic [1:0]       resp_op,
  output logic [31:0]      cap_data,
  output logic [1:0]       cap_op,
  output logic [1:0]       dmistat,
  output logic             busy
);

  dmi_state_e       state_q, state_d;
  dmi_stat_e        stat_q, stat_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d;
  logic [31:0]      req_data_q, req_data_d;
  logic [1:0]       req_op_q, req_op_d;
  logic [31:0]      cap_data_q, cap_data_d;

  logic tmo_clr;
  logic tmo_en;
  logic tmo_exp;
  logic busy_ev;
  logic fail_ev;
  logic op_ok;

  dp_dmi_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i    (iclk),
    .rst_i    (ireset),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_exp)
  );

  assign busy    = (state_q != S_IDLE);
  assign tmo_en  = (state_q == S_WAIT);
  assign busy_ev = busy && (dmi_upd || dmi_cap);
  assign op_ok   = (dmi_op == OP_READ) ||
                   (dmi_op == OP_WRITE);

  always_comb begin
    state_d    = state_q;
    stat_d     = stat_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_op_d   = req_op_q;
    cap_data_d = cap_data_q;
    tmo_clr    = 1'b0;
    fail_ev    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dmi_upd && (stat_q == ST_OK) && op_ok) begin
          req_addr_d = dmi_addr;
          req_data_d = dmi_wdata;
          req_op_d   = dmi_op;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          tmo_clr = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response in the expiry cycle still completes normally.
        if (resp_valid) begin
          if (req_op_q == OP_READ) begin
            cap_data_d = resp_data;
          end
          fail_ev = (resp_op != 2'd0);
          state_d = S_IDLE;
        end else if (tmo_exp) begin
          fail_ev = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sticky: only written from OK; a busy hit in the same
    // cycle as a failure is reported as busy.
    if (stat_q == ST_OK) begin
      if (busy_ev) begin
        stat_d = ST_BUSY;
      end else if (fail_ev) begin
        stat_d = ST_FAILED;
      end
    end

    if (dmireset) begin
      stat_d = ST_OK;
    end

    // Hard reset aborts everything the FSM would have done.
    if (dmihardreset) begin
      state_d    = S_IDLE;
      stat_d     = ST_OK;
      req_addr_d = req_addr_q;
      req_data_d = req_data_q;
      req_op_d   = req_op_q;
      cap_data_d = cap_data_q;
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q    <= S_IDLE;
      stat_q     <= ST_OK;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_op_q   <= '0;
      cap_data_q <= '0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_op_q   <= req_op_d;
      cap_data_q <= cap_data_d;
    end
  end

  assign req_valid  = (state_q == S_REQ);
  assign resp_ready = (state_q == S_WAIT);
  assign req_addr   = req_addr_q;
  assign req_data   = req_data_q;
  assign req_op     = req_op_q;
  assign cap_data   = cap_data_q;
  assign dmistat    = stat_q;
  assign cap_op     = busy ? 2'd3 : stat_q;

endmodule
